// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the table-driven sequence controller.
// Table writes are enabled by defining SEQ_CFG_WRITE_EN.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int DEF_NUM_LOAD = 4;
  localparam int DEF_NUM_MUX  = 3;
  localparam int DEF_MUX_W    = 2;
  localparam int DEF_DEPTH    = 8;

  // Word layout {LAST, LOOP_END, sel[NUM_MUX*MUX_W], ld[NUM_LOAD]}
  function automatic int cw_width(input int nl, input int nm, input int mw);
    return nl + nm * mw + 2;
  endfunction

  localparam int DEF_CW_W = cw_width(DEF_NUM_LOAD, DEF_NUM_MUX, DEF_MUX_W);

  // Flag bit positions, counted down from the word MSB
  localparam int LAST_OFS     = 1;
  localparam int LOOP_END_OFS = 2;

  typedef logic [DEF_CW_W-1:0] cw_t;

  // Original fixed controller: five steps, step 3 closes the body loop back to step 1
  localparam cw_t SEQ_DEFAULT_PROG [DEF_DEPTH] = '{
    12'h013, 12'h064, 12'h308, 12'h4B2, 12'h951, 12'h000, 12'h000, 12'h000
  };

endpackage

// File: rtl/seq_ctrl_table.sv
// Control-word storage with two combinational read ports.
// Writable only when SEQ_CFG_WRITE_EN is defined; otherwise a constant ROM.
module seq_ctrl_table
  import seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW_W  = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [CW_W-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  output logic [CW_W-1:0] rdata_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [CW_W-1:0] rdata_b
);

  logic [CW_W-1:0] rom [DEPTH];
  logic [CW_W-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    if (i < DEF_DEPTH) begin : g_def
      assign rom[i] = CW_W'(SEQ_DEFAULT_PROG[i]);
    end else begin : g_zero
      assign rom[i] = '0;
    end
  end

`ifdef SEQ_CFG_WRITE_EN
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= rom[i];
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{clk, RST, we, waddr, wdata};
  assign mem = rom;
`endif

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/seq_ctrl_unit.sv
// Table-driven datapath controller with loop count, stall, abort and start/done handshake.
// Define SEQ_CFG_WRITE_EN to make the control table writable via cfg_*.
module seq_ctrl_unit
  import seq_ctrl_pkg::*;
#(
  parameter int NUM_LOAD   = 4,
  parameter int NUM_MUX    = 3,
  parameter int MUX_W      = 2,
  parameter int DEPTH      = 8,
  parameter int ITER_W     = 4,
  parameter int LOOP_START = 1,
  parameter int AW         = $clog2(DEPTH),
  parameter int SEL_W      = NUM_MUX * MUX_W,
  parameter int CW_W       = cw_width(NUM_LOAD, NUM_MUX, MUX_W)
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                start,
  input  logic [ITER_W-1:0]   iter_count,
  input  logic                stall,
  input  logic                abort,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [CW_W-1:0]     cfg_data,
  output logic [NUM_LOAD-1:0] ld_en,
  output logic [SEL_W-1:0]    mux_sel,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       step
);

  state_t              state_q, state_d;
  logic [AW-1:0]       step_q, step_d;
  logic [ITER_W-1:0]   rem_q, rem_d;
  logic [NUM_LOAD-1:0] ld_q, ld_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CW_W-1:0]     cur_w, nxt_w;
  logic                cur_last, cur_loop;

  seq_ctrl_table #(.DEPTH(DEPTH), .CW_W(CW_W), .AW(AW)) u_table (
    .clk     (clk),
    .RST     (RST),
    .we      (cfg_we && state_q == S_IDLE),
    .waddr   (cfg_addr),
    .wdata   (cfg_data),
    .raddr_a (step_q),
    .rdata_a (cur_w),
    .raddr_b (step_d),
    .rdata_b (nxt_w)
  );

  assign cur_last = cur_w[CW_W-LAST_OFS];
  assign cur_loop = cur_w[CW_W-LOOP_END_OFS];

  logic unused_bits;
  assign unused_bits = ^{cur_w[CW_W-3:0], nxt_w[CW_W-1 -: 2]};

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      rem_q   <= '0;
      ld_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      ld_q    <= ld_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        step_d  = '0;
        rem_d   = (iter_count == '0) ? ITER_W'(1) : iter_count;
      end
      S_RUN: if (abort) begin
        state_d = S_IDLE;
        step_d  = '0;
      end else if (!stall) begin
        if (cur_last || step_q == AW'(DEPTH - 1)) begin
          state_d = S_DONE;
          step_d  = '0;
        end else if (cur_loop && rem_q > ITER_W'(1)) begin
          step_d = AW'(LOOP_START);
          rem_d  = rem_q - ITER_W'(1);
        end else begin
          step_d = step_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the word at the next step; a stalled step reloads its own word
  always_comb begin
    ld_d  = '0;
    sel_d = '0;
    if (state_d == S_RUN) begin
      ld_d  = nxt_w[NUM_LOAD-1:0];
      sel_d = nxt_w[NUM_LOAD +: SEL_W];
    end
  end

  // Stall masks loads in the cycle it is seen, so the step's loads land on the first free cycle
  assign ld_en   = ld_q & {NUM_LOAD{~(stall && state_q == S_RUN)}};
  assign mux_sel = sel_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign step    = step_q;

endmodule

// File: doc/seq_ctrl_unit.md
# seq_ctrl_unit

Parametrised, table-driven successor to the fixed datapath controller. It steps through a control-word table of up to DEPTH entries; each entry drives load enables and mux selects for the arithmetic datapath. Over the fixed controller it adds a loop count over a body range, stall, abort and a start/busy/done handshake. It sits between the system sequencer (start/done) and the datapath registers and muxes.

## Interface
- NUM_LOAD, 4, number of load-enable outputs
- NUM_MUX, 3, number of mux-select fields
- MUX_W, 2, width of each mux select
- DEPTH, 8, control table entries (power of two, ≥2)
- ITER_W, 4, loop-count width
- LOOP_START, 1, step index jumped to at a loop end (< DEPTH)

- clk  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- start  in  1  launch request, sampled in IDLE only
- iter_count  in  ITER_W  body passes, latched at launch; 0 means 1
- stall  in  1  freeze current step
- abort  in  1  cancel run
- cfg_we  in  1  table write strobe
- cfg_addr  in  clog2(DEPTH)  table write address
- cfg_data  in  CW_W  control word {LAST, LOOP_END, sel[NUM_MUX*MUX_W], ld[NUM_LOAD]}
- ld_en  out  NUM_LOAD  registered load enables
- mux_sel  out  NUM_MUX*MUX_W  registered mux selects, field i = bits [i*MUX_W +: MUX_W]
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- step  out  clog2(DEPTH)  current table index

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. All outputs are 0 at reset. The table is loaded with the package default program.
- IDLE → RUN when start=1:
  - step=0
  - remaining iterations = max(iter_count, 1)
  - outputs = word[0]
- RUN, stall=0, advance from current word w:
  - w.LAST=1, or step=DEPTH-1 → DONE.
  - w.LOOP_END=1 and remaining>1 → step=LOOP_START, remaining decrements.
  - Otherwise → step+1.
  - Outputs take the new word's fields.
- RUN, stall=1:
  - step, remaining and mux_sel hold.
  - ld_en is forced to 0 for that cycle.
  - The step's loads are issued on its first unstalled cycle.
- abort=1 in RUN → IDLE next edge. Outputs go to 0 and no done pulse is produced. abort has priority over stall and advance. abort is ignored outside RUN.
- DONE: done=1, ld_en=0, mux_sel=0, busy=0 for exactly one cycle, then → IDLE.
- start in RUN or DONE is ignored and is not queued.
- The remaining-iteration counter is ITER_W bits and never wraps. LOOP_END with remaining=1 falls through to step+1.

## Timing
- Launch latency: start sampled at edge k → busy and word[0] outputs valid after edge k.
- One step per unstalled cycle. An N-word program with no loops gives busy for N cycles, then done for 1 cycle.
- cfg write takes effect at the edge. It is accepted only in IDLE and ignored in RUN and DONE.
- Reset mid-run is asynchronous: immediate return to IDLE with all outputs 0. The table reverts to the default program.

## Configuration
- SEQ_CFG_WRITE_EN defined: the table is writable through cfg_we/cfg_addr/cfg_data.
- SEQ_CFG_WRITE_EN undefined: the table is the package constant only. The cfg ports remain present and are ignored; synthesis removes the table registers in favour of constant logic.

## Structure
- Package seq_ctrl_pkg holds:
  - state enum
  - CW_W computation function
  - LAST/LOOP_END bit-position constants
  - SEQ_DEFAULT_PROG, which reproduces the original fixed controller sequence
- Sub-module seq_ctrl_table: DEPTH×CW_W storage with write port and combinational read. Its write path is under the macro.

## Test plan
- Default program, iter_count=0, start pulse → busy for the program length, each step's ld_en/mux_sel match SEQ_DEFAULT_PROG, then done=1 for one cycle, then IDLE.
- Write words 0..3 with word1 LOOP_END, word3 LAST, iter_count=3 → step sequence 0,1,1,1,2,3, then done.
- stall held 2 cycles at step 2 → step stays 2, ld_en=0 during the stall, word[2] loads appear on release, total busy extended by 2.
- abort at step 1 → IDLE next edge, outputs 0, no done. A new start then restarts at step 0.
- RST low mid-run at step 2 → outputs 0 immediately. The table holds the default program; the cfg write made before the run is lost.
- cfg_we and start pulses while busy → table unchanged, run unaffected, no second run.
